mac_bus_sequencer: RTL and testbench

Parametrised bus-cycle sequencer for the Mac core: generates the bus phase counter and the alternating CPU/video slot schedule, arbitrates N DMA channels (video, sound, refresh, …) into the video slot, qualifies 68000 /AS, and produces /DTACK and /VPA with per-region wait states. It also stretches system reset after external or CPU-issued reset. It sits between the fx68k core, the address decoder and the memory/data controllers, replacing hand-wired phase, DTACK and reset logic at the top level.

---
 rtl/mac_bus_sequencer.sv | 130 +++++++++++++
 tb/tb_mac_bus_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_bus_sequencer.sv
// Mac bus-cycle sequencer: phase counter, CPU/video slot schedule, DMA arbitration,
// /AS qualification, /DTACK and /VPA generation, and system reset stretching.
module mac_bus_sequencer #(
  parameter int          PHASE_BITS   = 3,
  parameter int          CHANNELS     = 3,
  parameter int          AS_PHASE     = 2,
  parameter int          DONE_PHASE   = 4,
  parameter int          ROM_WAIT     = 0,
  parameter logic [15:0] RESET_CYCLES = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  soft_reset,
  input  logic                  cpu_reset_o_n,
  output logic [PHASE_BITS-1:0] bus_phase,
  output logic                  cycle_ready,
  output logic                  video_slot,
  output logic                  cpu_slot,
  input  logic [CHANNELS-1:0]   dma_req,
  output logic [CHANNELS-1:0]   dma_gnt,
  input  logic                  cpu_as_n,
  input  logic [2:0]            cpu_fc,
  input  logic                  sel_ram,
  input  logic                  sel_rom,
  input  logic                  sel_via,
  output logic                  cpu_on_video,
  output logic                  cpu_dtack_n,
  output logic                  cpu_vpa_n,
  output logic                  sys_reset_n
);

  localparam logic [PHASE_BITS-1:0] LAST_PHASE = '1;
  localparam logic [PHASE_BITS-1:0] AS_PH      = AS_PHASE[PHASE_BITS-1:0];
  localparam logic [PHASE_BITS-1:0] DONE_PH    = DONE_PHASE[PHASE_BITS-1:0];
  localparam logic [3:0]            ROM_WAIT_L = ROM_WAIT[3:0];

  logic        as_q;
  logic        rom_loaded;
  logic [3:0]  wait_cnt;
  logic [15:0] stretch_cnt;
  logic [15:0] stretch_nxt;
  logic        ram_done;
  logic        rom_done;
  logic        unmapped;

  // Fixed priority: the lowest-numbered active request wins.
  function automatic logic [CHANNELS-1:0] pick_channel(input logic [CHANNELS-1:0] req);
    logic [CHANNELS-1:0] g;
    g = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (req[i]) begin
        g    = '0;
        g[i] = 1'b1;
      end
    end
    return g;
  endfunction

  assign cycle_ready = (bus_phase == LAST_PHASE);
  assign cpu_slot    = ~video_slot;

  // Phase counter, slot schedule and grant, all advancing on the bus-cycle boundary.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      bus_phase  <= '0;
      video_slot <= 1'b1;
      dma_gnt    <= '0;
    end else begin
      bus_phase <= bus_phase + 1'b1;
      if (cycle_ready) begin
        video_slot <= ~video_slot;
        dma_gnt    <= video_slot ? '0 : pick_channel(dma_req);
      end
    end
  end

  // /AS qualification and ROM wait-state counting.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      as_q       <= 1'b0;
      rom_loaded <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      if (bus_phase == AS_PH)
        as_q <= ~cpu_as_n;
      else if (cycle_ready && cpu_as_n)
        as_q <= 1'b0;

      if (cpu_as_n) begin
        rom_loaded <= 1'b0;
        wait_cnt   <= '0;
      end else if (bus_phase == AS_PH && sel_rom && !rom_loaded) begin
        rom_loaded <= 1'b1;
        wait_cnt   <= ROM_WAIT_L;
      end else if (cycle_ready && as_q && sel_rom && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
    end
  end

  // A reload request always overrides the countdown, even when it would reach zero.
  always_comb begin
    stretch_nxt = stretch_cnt;
    if (soft_reset || !cpu_reset_o_n)
      stretch_nxt = RESET_CYCLES;
    else if (cycle_ready && stretch_cnt != '0)
      stretch_nxt = stretch_cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      stretch_cnt <= RESET_CYCLES;
      sys_reset_n <= 1'b0;
    end else begin
      stretch_cnt <= stretch_nxt;
      sys_reset_n <= (stretch_nxt == '0);
    end
  end

  assign cpu_on_video = video_slot & (dma_gnt == '0) & as_q & sel_ram & ~cpu_as_n;

  assign ram_done = ~cpu_as_n & as_q & sel_ram & (cpu_slot | cpu_on_video) & (bus_phase >= DONE_PH);
  assign rom_done = ~cpu_as_n & as_q & sel_rom & (wait_cnt == '0) & (bus_phase >= DONE_PH);
  // Unmapped space terminates immediately so a stray access cannot hang the CPU.
  assign unmapped = ~cpu_as_n & ~sel_ram & ~sel_rom & ~sel_via;

  assign cpu_dtack_n = ~(ram_done | rom_done | unmapped);
  assign cpu_vpa_n   = (cpu_fc == 3'b111) ? 1'b0 : ~(~cpu_as_n & sel_via);

endmodule

// File: tb/tb_mac_bus_sequencer.sv
// Directed bench for mac_bus_sequencer with a slot-level behavioural model checked every cycle.
module tb_mac_bus_sequencer;
  localparam int ROM_WAIT_TB = 2;
  localparam int RC_TB       = 4;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       soft_reset;
  logic       cpu_reset_o_n;
  logic [2:0] bus_phase;
  logic       cycle_ready;
  logic       video_slot;
  logic       cpu_slot;
  logic [2:0] dma_req;
  logic [2:0] dma_gnt;
  logic       cpu_as_n;
  logic [2:0] cpu_fc;
  logic       sel_ram;
  logic       sel_rom;
  logic       sel_via;
  logic       cpu_on_video;
  logic       cpu_dtack_n;
  logic       cpu_vpa_n;
  logic       sys_reset_n;

  int n_checks = 0;
  int n_fail   = 0;

  mac_bus_sequencer #(
    .PHASE_BITS(3), .CHANNELS(3), .AS_PHASE(2), .DONE_PHASE(4),
    .ROM_WAIT(ROM_WAIT_TB), .RESET_CYCLES(16'd4)
  ) dut (
    .clk(clk), .n_reset(n_reset), .soft_reset(soft_reset), .cpu_reset_o_n(cpu_reset_o_n),
    .bus_phase(bus_phase), .cycle_ready(cycle_ready), .video_slot(video_slot), .cpu_slot(cpu_slot),
    .dma_req(dma_req), .dma_gnt(dma_gnt), .cpu_as_n(cpu_as_n), .cpu_fc(cpu_fc),
    .sel_ram(sel_ram), .sel_rom(sel_rom), .sel_via(sel_via), .cpu_on_video(cpu_on_video),
    .cpu_dtack_n(cpu_dtack_n), .cpu_vpa_n(cpu_vpa_n), .sys_reset_n(sys_reset_n)
  );

  always #5 clk = ~clk;

  // Model state: clocks since reset release, slot = tick/8 (even slots are video).
  int         m_tick;
  logic [2:0] m_gnt;
  logic       m_asq;
  int         m_rom_slot;
  int         m_ends;

  function automatic logic [2:0] lowest_req(input logic [2:0] r);
    for (int i = 0; i < 3; i++)
      if (r[i]) return 3'(1 << i);
    return 3'b000;
  endfunction

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      m_tick     <= 0;
      m_gnt      <= 3'b000;
      m_asq      <= 1'b0;
      m_rom_slot <= -1;
      m_ends     <= 0;
    end else begin
      m_tick <= m_tick + 1;
      if (m_tick % 8 == 7)
        m_gnt <= (((m_tick / 8) % 2) == 0) ? 3'b000 : lowest_req(dma_req);
      if (m_tick % 8 == 2)
        m_asq <= !cpu_as_n;
      else if (m_tick % 8 == 7 && cpu_as_n)
        m_asq <= 1'b0;
      if (cpu_as_n)
        m_rom_slot <= -1;
      else if (m_tick % 8 == 2 && sel_rom && m_rom_slot < 0)
        m_rom_slot <= m_tick / 8;
      if (soft_reset || !cpu_reset_o_n)
        m_ends <= 0;
      else if (m_tick % 8 == 7 && m_ends < RC_TB)
        m_ends <= m_ends + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    int   ph;
    logic e_video, e_onv, rom_ok, e_done, e_dtack, e_vpa;
    forever begin
      @(negedge clk);
      ph      = m_tick % 8;
      e_video = ((m_tick / 8) % 2) == 0;
      e_onv   = e_video && m_gnt == 3'b000 && m_asq && sel_ram && !cpu_as_n;
      rom_ok  = (m_rom_slot < 0) || ((m_tick / 8) - m_rom_slot >= ROM_WAIT_TB);
      e_done  = (!cpu_as_n && m_asq && sel_ram && (!e_video || e_onv) && ph >= 4) ||
                (!cpu_as_n && m_asq && sel_rom && rom_ok && ph >= 4) ||
                (!cpu_as_n && !sel_ram && !sel_rom && !sel_via);
      e_dtack = !e_done;
      e_vpa   = (cpu_fc == 3'b111) ? 1'b0 : !(!cpu_as_n && sel_via);
      chk("m_bus_phase", 32'(bus_phase), 32'(ph));
      chk("m_cycle_ready", 32'(cycle_ready), 32'(ph == 7));
      chk("m_video_slot", 32'(video_slot), 32'(e_video));
      chk("m_cpu_slot", 32'(cpu_slot), 32'(!e_video));
      chk("m_dma_gnt", 32'(dma_gnt), 32'(m_gnt));
      chk("m_cpu_on_video", 32'(cpu_on_video), 32'(e_onv));
      chk("m_cpu_dtack_n", 32'(cpu_dtack_n), 32'(e_dtack));
      chk("m_cpu_vpa_n", 32'(cpu_vpa_n), 32'(e_vpa));
      chk("m_sys_reset_n", 32'(sys_reset_n), 32'(m_ends >= RC_TB));
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Advance until the current cycle is the given phase; want: 0 CPU slot, 1 video slot, 2 either.
  task automatic goto_slot(input int want, input int ph);
    logic vid;
    for (int k = 0; k < 40; k++) begin
      vid = ((m_tick / 8) % 2) == 0;
      if ((m_tick % 8) == ph && (want == 2 || int'(vid) == want)) return;
      step(1);
    end
    n_checks++;
    n_fail++;
    $display("FAIL goto_timeout: phase %0d slot %0d not reached", ph, want);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_reset = 1'b0; soft_reset = 1'b0; cpu_reset_o_n = 1'b1;
    dma_req = 3'b000; cpu_as_n = 1'b1; cpu_fc = 3'b000;
    sel_ram = 1'b0; sel_rom = 1'b0; sel_via = 1'b0;
    fork
      compare_loop();
    join_none

    // Reset state and release
    step(3);
    chk("rst_phase", 32'(bus_phase), 0);
    chk("rst_video", 32'(video_slot), 1);
    chk("rst_gnt", 32'(dma_gnt), 0);
    chk("rst_sys", 32'(sys_reset_n), 0);
    chk("rst_dtack", 32'(cpu_dtack_n), 1);
    n_reset = 1'b1;
    step(7);
    chk("ph7_phase", 32'(bus_phase), 7);
    chk("ph7_ready", 32'(cycle_ready), 1);
    chk("ph7_video", 32'(video_slot), 1);
    step(1);
    chk("wrap_phase", 32'(bus_phase), 0);
    chk("wrap_video", 32'(video_slot), 0);
    step(23);
    chk("stretch_31", 32'(sys_reset_n), 0);
    step(1);
    chk("stretch_32", 32'(sys_reset_n), 1);

    // Arbitration: grant sampled at CPU-slot end, immune to mid-slot changes
    goto_slot(0, 3);
    dma_req = 3'b110;
    goto_slot(1, 0);
    chk("gnt_first", 32'(dma_gnt), 3'b010);
    goto_slot(1, 3);
    dma_req = 3'b011;
    goto_slot(1, 7);
    chk("gnt_held", 32'(dma_gnt), 3'b010);
    goto_slot(0, 0);
    chk("gnt_cpu_clear", 32'(dma_gnt), 3'b000);
    goto_slot(1, 0);
    chk("gnt_second", 32'(dma_gnt), 3'b001);
    dma_req = 3'b000;

    // RAM read with /AS at phase 1 of a CPU slot
    goto_slot(0, 1);
    cpu_as_n = 1'b0; sel_ram = 1'b1;
    step(2);
    chk("ram_ph3", 32'(cpu_dtack_n), 1);
    step(1);
    chk("ram_ph4", 32'(cpu_dtack_n), 0);
    cpu_as_n = 1'b1; sel_ram = 1'b0;

    // Late /AS, idle video slot: CPU borrows it
    goto_slot(0, 3);
    cpu_as_n = 1'b0; sel_ram = 1'b1;
    step(1);
    chk("late_cpu_ph4", 32'(cpu_dtack_n), 1);
    goto_slot(1, 3);
    chk("borrow_ph3", 32'(cpu_on_video), 1);
    step(1);
    chk("borrow_ph4", 32'(cpu_dtack_n), 0);
    cpu_as_n = 1'b1; sel_ram = 1'b0;

    // Late /AS, granted video slot: DTACK waits for the next CPU slot
    goto_slot(0, 3);
    dma_req = 3'b100; cpu_as_n = 1'b0; sel_ram = 1'b1;
    goto_slot(1, 4);
    chk("gnt_ch2", 32'(dma_gnt), 3'b100);
    chk("granted_vid_dtack", 32'(cpu_dtack_n), 1);
    goto_slot(0, 3);
    chk("next_cpu_ph3", 32'(cpu_dtack_n), 1);
    step(1);
    chk("next_cpu_ph4", 32'(cpu_dtack_n), 0);
    cpu_as_n = 1'b1; sel_ram = 1'b0; dma_req = 3'b000;

    // ROM with two wait cycles
    goto_slot(0, 1);
    cpu_as_n = 1'b0; sel_rom = 1'b1;
    step(3);
    chk("rom_first_ph4", 32'(cpu_dtack_n), 1);
    step(15);
    chk("rom_wait_ph3", 32'(cpu_dtack_n), 1);
    step(1);
    chk("rom_done_ph4", 32'(cpu_dtack_n), 0);
    cpu_as_n = 1'b1; sel_rom = 1'b0;

    // VIA, autovector and unmapped accesses
    goto_slot(0, 1);
    cpu_as_n = 1'b0; sel_via = 1'b1; cpu_fc = 3'b101;
    #1;
    chk("via_vpa", 32'(cpu_vpa_n), 0);
    chk("via_dtack", 32'(cpu_dtack_n), 1);
    step(4);
    chk("via_dtack_ph5", 32'(cpu_dtack_n), 1);
    cpu_as_n = 1'b1; sel_via = 1'b0; cpu_fc = 3'b111;
    #1;
    chk("autovec_vpa", 32'(cpu_vpa_n), 0);
    step(1);
    cpu_fc = 3'b000;
    #1;
    chk("idle_vpa", 32'(cpu_vpa_n), 1);
    step(1);
    cpu_as_n = 1'b0;
    #1;
    chk("unmapped_dtack", 32'(cpu_dtack_n), 0);
    step(1);
    cpu_as_n = 1'b1;
    #1;
    chk("unmapped_release", 32'(cpu_dtack_n), 1);

    // CPU RESET instruction pulse on a cycle_ready clock
    goto_slot(2, 7);
    cpu_reset_o_n = 1'b0;
    step(1);
    cpu_reset_o_n = 1'b1;
    chk("cpurst_drop", 32'(sys_reset_n), 0);
    step(31);
    chk("cpurst_31", 32'(sys_reset_n), 0);
    step(1);
    chk("cpurst_32", 32'(sys_reset_n), 1);

    // Soft reset mid-cycle
    goto_slot(2, 3);
    soft_reset = 1'b1;
    step(1);
    soft_reset = 1'b0;
    chk("soft_drop", 32'(sys_reset_n), 0);
    step(27);
    chk("soft_27", 32'(sys_reset_n), 0);
    step(1);
    chk("soft_28", 32'(sys_reset_n), 1);

    // Asynchronous reset in the middle of a granted video slot
    goto_slot(0, 3);
    dma_req = 3'b001;
    goto_slot(1, 3);
    chk("pre_abort_gnt", 32'(dma_gnt), 3'b001);
    n_reset = 1'b0;
    #1;
    chk("abort_gnt", 32'(dma_gnt), 0);
    chk("abort_phase", 32'(bus_phase), 0);
    chk("abort_video", 32'(video_slot), 1);
    chk("abort_sys", 32'(sys_reset_n), 0);
    step(2);
    n_reset = 1'b1;
    dma_req = 3'b000;
    step(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
